// File: rtl/iro_freq_meter.sv
// Gated rising-edge counter for the ring-oscillator phase bus, used to measure its frequency on-chip.
// Optional phase snapshot enabled with `define IRO_FREQ_METER_SNAPSHOT_EN.
`timescale 1ns/1ps
module iro_freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       phases,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [15:0]       snapshot
);

`ifdef IRO_FREQ_METER_SNAPSHOT_EN
    localparam int SYNC_W = 16;
`else
    localparam int SYNC_W = 1;
`endif

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t              state_q;
    logic                armCnt_q;
    logic [GATE_W-1:0]   winCnt_q;
    logic [CNT_W-1:0]    count_q;
    logic                overflow_q;
    logic                busy_q;
    logic                done_q;
    logic [SYNC_W-1:0]   s1_q;
    logic [SYNC_W-1:0]   s2_q;
    logic                s3_q;

    logic                rise;
    logic                toDone;
    logic [CNT_W-1:0]    count_d;
    logic                overflow_d;

    // Two-flop synchroniser plus one extra stage of bit 0 for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= phases[SYNC_W-1:0];
            s2_q <= s1_q;
            s3_q <= s2_q[0];
        end
    end

    assign rise   = s2_q[0] & ~s3_q;
    assign toDone = ((state_q == ARM) && armCnt_q && (winCnt_q == '0)) ||
                    ((state_q == GATE) && (winCnt_q == GATE_W'(1)));

    // Saturating accumulate: a rise on an all-ones count only flags overflow
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (rise) begin
            if (&count_q) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armCnt_q   <= 1'b0;
            winCnt_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= toDone;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        winCnt_q   <= gate_cycles;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        armCnt_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ARM;
                    end
                end
                ARM: begin
                    armCnt_q <= 1'b1;
                    if (armCnt_q) begin
                        state_q <= (winCnt_q == '0) ? DONE : GATE;
                    end
                end
                GATE: begin
                    winCnt_q   <= winCnt_q - GATE_W'(1);
                    count_q    <= count_d;
                    overflow_q <= overflow_d;
                    if (winCnt_q == GATE_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IRO_FREQ_METER_SNAPSHOT_EN
    logic [15:0] snapshot_q;

    // Captured on the edge into DONE so the word is visible alongside done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot_q <= '0;
        end else if (toDone) begin
            snapshot_q <= s2_q;
        end
    end

    assign snapshot = snapshot_q;
`else
    logic unused_phases;
    assign unused_phases = ^phases[15:1];
    assign snapshot      = 16'h0000;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_iro_freq_meter.sv
// Directed bench for iro_freq_meter: a default-width instance and a CNT_W=4 instance share all stimulus.
`timescale 1ns/1ps
module tb_iro_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] phases = 16'h0000;
    logic        start = 1'b0;
    logic [15:0] gate_cycles = 16'h0000;

    logic        busy0, done0, ovf0;
    logic [15:0] count0, snap0;
    logic        busy1, done1, ovf1;
    logic [3:0]  count1;
    logic [15:0] snap1;

    int checks   = 0;
    int failures = 0;

    // Phase generator: 0 = constant word, 1 = period-4 square on bit 0, 2 = period-2 toggle
    int          waveMode = 0;
    logic [15:0] constPh  = 16'h0000;
    logic [31:0] tick     = 0;

    iro_freq_meter #(.GATE_W(16), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .phases(phases), .start(start), .gate_cycles(gate_cycles),
        .busy(busy0), .done(done0), .count(count0), .overflow(ovf0), .snapshot(snap0)
    );

    iro_freq_meter #(.GATE_W(16), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .phases(phases), .start(start), .gate_cycles(gate_cycles),
        .busy(busy1), .done(done1), .count(count1), .overflow(ovf1), .snapshot(snap1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick = tick + 1;
        case (waveMode)
            1:       phases = {15'h0000, tick[1]};
            2:       phases = {15'h0000, tick[0]};
            default: phases = constPh;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Accept one measurement; returns cycles from the start cycle to done and busy-high cycles
    task automatic applyStimulus(input logic [15:0] n, input int pulseAt,
                                 output int doneAt, output int busyLen);
        start       = 1'b1;
        gate_cycles = n;
        step();
        start       = 1'b0;
        gate_cycles = 16'($urandom);
        doneAt      = -1;
        busyLen     = 0;
        for (int i = 1; i <= 400; i++) begin
            if (busy0) busyLen++;
            if (done0) begin
                doneAt = i;
                break;
            end
            start = (i == pulseAt);
            step();
        end
        start = 1'b0;
        step();
        if (busy0) busyLen++;
    endtask

    int doneAt, busyLen, gap;
    logic sawDone;

    initial begin
        $display("[TB] starting");
        #1;
        checkOutput("reset_busy", busy0, 1'b0);
        checkOutput("reset_done", done0, 1'b0);
        checkOutput("reset_count", count0, 16'h0);
        checkOutput("reset_overflow", ovf0, 1'b0);
        checkOutput("reset_snapshot", snap0, 16'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // Zero-length window
        applyStimulus(16'd0, -1, doneAt, busyLen);
        checkOutput("n0_done_latency", doneAt, 3);
        checkOutput("n0_count", count0, 16'h0);
        checkOutput("n0_busy_len", busyLen, 3);

        // Period-4 square wave, 64-cycle window: exactly 16 rises
        waveMode = 1;
        repeat (8) step();
        applyStimulus(16'd64, -1, doneAt, busyLen);
        checkOutput("p4_done_latency", doneAt, 67);
        checkOutput("p4_count", count0, 16'd16);
        checkOutput("p4_overflow", ovf0, 1'b0);
        checkOutput("p4_busy_len", busyLen, 67);
        checkOutput("p4_w4_count", count1, 4'd15);
        checkOutput("p4_w4_overflow", ovf1, 1'b1);

        // Period-2 toggle: 32 rises, saturating in the narrow instance
        waveMode = 2;
        repeat (8) step();
        applyStimulus(16'd64, -1, doneAt, busyLen);
        checkOutput("p2_count", count0, 16'd32);
        checkOutput("p2_overflow", ovf0, 1'b0);
        checkOutput("p2_w4_count", count1, 4'd15);
        checkOutput("p2_w4_overflow", ovf1, 1'b1);
        repeat (6) step();
        checkOutput("p2_w4_count_held", count1, 4'd15);
        checkOutput("p2_w4_overflow_held", ovf1, 1'b1);
        checkOutput("p2_count_held", count0, 16'd32);

        // Start pulsed mid-window must not disturb timing
        waveMode = 1;
        repeat (8) step();
        applyStimulus(16'd20, 10, doneAt, busyLen);
        checkOutput("ignore_start_latency", doneAt, 23);
        checkOutput("ignore_start_count", count0, 16'd5);
        step();
        checkOutput("ignore_start_idle", busy0, 1'b0);

        // Constant phase word for snapshot
        waveMode = 0;
        constPh  = 16'hA5C3;
        repeat (6) step();
        applyStimulus(16'd8, -1, doneAt, busyLen);
        checkOutput("snap_latency", doneAt, 11);
        checkOutput("snap_count", count0, 16'h0);
`ifdef IRO_FREQ_METER_SNAPSHOT_EN
        checkOutput("snap_value", snap0, 16'hA5C3);
`else
        checkOutput("snap_value", snap0, 16'h0000);
`endif

        // Start held high: back-to-back runs with one IDLE cycle between
        start       = 1'b1;
        gate_cycles = 16'd2;
        sawDone     = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done0) begin
                sawDone = 1'b1;
                break;
            end
        end
        checkOutput("b2b_first_done", sawDone, 1'b1);
        step();
        checkOutput("b2b_idle_gap", busy0, 1'b0);
        step();
        checkOutput("b2b_rearmed", busy0, 1'b1);
        gap = -1;
        for (int j = 3; j <= 50; j++) begin
            step();
            if (done0) begin
                gap = j;
                break;
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_spacing", gap, 6);
        repeat (4) step();

        // Reset asserted 40 cycles into a 100-cycle window
        waveMode    = 1;
        start       = 1'b1;
        gate_cycles = 16'd100;
        step();
        start = 1'b0;
        repeat (2 + 40) step();
        checkOutput("midrst_busy_before", busy0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy0, 1'b0);
        checkOutput("midrst_count", count0, 16'h0);
        checkOutput("midrst_done", done0, 1'b0);
        checkOutput("midrst_overflow", ovf0, 1'b0);
        checkOutput("midrst_snapshot", snap0, 16'h0);
        step();
        rst     = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (done0 || busy0) sawDone = 1'b1;
        end
        checkOutput("midrst_no_done", sawDone, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
